// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin scan engine for the ADC128S022 8-channel SPI ADC with a result bank.
// Define ADC_OBSTACLE_FLAGS_EN to build the per-channel threshold compare driving obstacle.
module adc_scan_sequencer #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ch_enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_saddr,
    input  logic        adc_sdat,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    input  logic [11:0] threshold,
    output logic [7:0]  obstacle
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_high;
    logic [3:0]    r_per;
    logic [2:0]    r_cur_ch, r_next_ch;
    logic [10:0]   r_shift;
    logic          r_saddr;
    logic          r_valid;
    logic [2:0]    r_sample_ch;
    logic [11:0]   r_sample_data;
    logic [11:0]   r_bank [8];

    logic          w_last, w_frame_end, w_run, w_wr;
    logic [2:0]    w_ch_base, w_next_ch;
    logic [11:0]   w_result;
    logic [15:0]   w_ctrl;

    function automatic logic [2:0] f_next_ch(input logic [2:0] base, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        f_next_ch = base;
        found     = 1'b0;
        for (int unsigned i = 1; i < 8; i++) begin
            idx = base + 3'(i);
            if (!found && mask[idx]) begin
                f_next_ch = idx;
                found     = 1'b1;
            end
        end
    endfunction

    assign w_last      = (r_cnt == LAST);
    assign w_frame_end = (r_state == SHIFT) && r_high && w_last && (r_per == 4'd15);
    assign w_run       = enable && (|ch_enable);
    // At frame end cur_ch is about to become next_ch, so the new lookup starts from there.
    assign w_ch_base   = (r_state == SHIFT) ? r_next_ch : r_cur_ch;
    assign w_next_ch   = f_next_ch(w_ch_base, ch_enable);
    assign w_result    = {r_shift, adc_sdat};
    assign w_ctrl      = {2'b00, r_next_ch, 11'd0};
    assign w_wr        = w_frame_end && ch_enable[r_cur_ch];

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        adc_cs_n    = 1'b1;
        adc_sclk    = 1'b1;
        case (r_state)
            IDLE:  if (w_run && w_last) w_state_nxt = SETUP;
            SETUP: begin
                adc_cs_n = 1'b0;
                if (w_last) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = r_high;
                if (w_frame_end && !w_run) w_state_nxt = HOLD;
            end
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // In IDLE r_cnt counts CS-high cycles (saturating) to enforce the minimum gap between runs.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_cnt     <= LAST;
            r_high    <= 1'b0;
            r_per     <= '0;
            r_cur_ch  <= '0;
            r_next_ch <= '0;
            r_shift   <= '0;
            r_saddr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_state_nxt == SETUP) begin
                        r_cnt    <= '0;
                        r_cur_ch <= '0;
                    end else if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETUP: begin
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_high    <= 1'b0;
                        r_per     <= '0;
                        r_saddr   <= 1'b0;
                        r_next_ch <= w_next_ch;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!r_high) begin
                        r_cnt  <= '0;
                        r_high <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_high  <= 1'b0;
                        r_shift <= {r_shift[9:0], adc_sdat};
                        if (r_per == 4'd15) begin
                            r_per    <= '0;
                            r_saddr  <= 1'b0;
                            r_cur_ch <= r_next_ch;
                            if (w_run) r_next_ch <= w_next_ch;
                        end else begin
                            r_per   <= r_per + 4'd1;
                            r_saddr <= w_ctrl[4'd14 - r_per];
                        end
                    end
                end
                HOLD:    r_cnt <= CW'(1);
                default: r_cnt <= LAST;
            endcase
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_sample_ch   <= '0;
            r_sample_data <= '0;
            for (int unsigned i = 0; i < 8; i++) r_bank[i] <= '0;
        end else begin
            r_valid <= w_wr;
            if (w_wr) begin
                r_sample_ch        <= r_cur_ch;
                r_sample_data      <= w_result;
                r_bank[r_cur_ch]   <= w_result;
            end
        end
    end

`ifdef ADC_OBSTACLE_FLAGS_EN
    logic [7:0] r_obstacle;
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset)     r_obstacle <= '0;
        else if (w_wr) r_obstacle[r_cur_ch] <= (w_result >= threshold);
    end
    assign obstacle = r_obstacle;
`else
    logic w_unused_threshold;
    assign w_unused_threshold = ^threshold;
    assign obstacle = 8'h00;
`endif

    assign adc_saddr    = r_saddr;
    assign sample_valid = r_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_data  = r_sample_data;
    assign rd_data      = r_bank[rd_ch];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC128S022 model.
// Obstacle expectations follow ADC_OBSTACLE_FLAGS_EN when the bench is built with it.
module tb_adc_scan_sequencer;
    logic        clk_50 = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  ch_enable;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_saddr;
    logic        adc_sdat = 1'b0;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic [11:0] threshold;
    logic [7:0]  obstacle;

`ifdef ADC_OBSTACLE_FLAGS_EN
    localparam logic [7:0] OBS_HI = 8'h02;
`else
    localparam logic [7:0] OBS_HI = 8'h00;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    adc_scan_sequencer #(.CLK_DIV(16)) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .enable      (enable),
        .ch_enable   (ch_enable),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_saddr   (adc_saddr),
        .adc_sdat    (adc_sdat),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch),
        .sample_data (sample_data),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .threshold   (threshold),
        .obstacle    (obstacle)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // ADC model: DOUT shifts out on SCLK falls (4 zeros then D11..D0), DIN captured on rises.
    logic [11:0] m_val [8];
    logic [2:0]  m_ch = '0;
    logic [15:0] m_ctrl = '0;
    logic [15:0] m_word;
    logic        m_sclk_q = 1'b1;
    int          m_fall = 0;
    int          m_rise = 0;
    int          m_edges = 0;
    logic [2:0]  q_addr [$];

    always @(negedge clk_50) begin
        if (m_sclk_q === 1'b1 && adc_sclk === 1'b0) m_edges++;
        if (adc_cs_n !== 1'b0) begin
            m_ch   = '0;
            m_fall = 0;
            m_rise = 0;
        end else begin
            if (m_sclk_q === 1'b1 && adc_sclk === 1'b0 && m_fall < 16) begin
                m_word   = {4'h0, m_val[m_ch]};
                adc_sdat = m_word[15 - m_fall];
                m_fall++;
            end
            if (m_sclk_q === 1'b0 && adc_sclk === 1'b1) begin
                m_ctrl = {m_ctrl[14:0], adc_saddr};
                m_rise++;
                if (m_rise == 16) begin
                    q_addr.push_back(m_ctrl[13:11]);
                    m_ch   = m_ctrl[13:11];
                    m_rise = 0;
                    m_fall = 0;
                end
            end
        end
        m_sclk_q = adc_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_50); #1;
            if (sample_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_50);
        #1;
    endtask

    task automatic start_run(output int t_cs);
        @(negedge clk_50);
        enable = 1'b1;
        @(posedge clk_50); #1;
        t_cs = cyc;
        chk("cs_low_at_start", {31'd0, adc_cs_n}, 32'd0);
    endtask

    initial begin
        int t_cs, at, prev, edges, q0;
        logic [2:0] exp_ch [5];
        logic [2:0] exp_addr [4];
        exp_ch   = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        exp_addr = '{3'd2, 3'd7, 3'd0, 3'd2};

        reset = 1'b1; enable = 1'b0; ch_enable = 8'h00; rd_ch = 3'd0; threshold = 12'h800;
        for (int i = 0; i < 8; i++) m_val[i] = 12'h000;
        m_val[0] = 12'hA5C;
        cycles(3);
        chk("rst_cs_n",  {31'd0, adc_cs_n}, 32'd1);
        chk("rst_sclk",  {31'd0, adc_sclk}, 32'd1);
        chk("rst_saddr", {31'd0, adc_saddr}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_data",  {20'd0, sample_data}, 32'd0);
        chk("rst_rd",    {20'd0, rd_data}, 32'd0);
        chk("rst_obst",  {24'd0, obstacle}, 32'd0);
        @(negedge clk_50);
        reset = 1'b0;
        ch_enable = 8'h01;

        // Single channel IN0: start latency, data and bank read.
        start_run(t_cs);
        wait_valid("t1", 700, at);
        chk("t1_latency", at - t_cs, 32'd528);
        chk("t1_ch",   {29'd0, sample_ch}, 32'd0);
        chk("t1_data", {20'd0, sample_data}, 32'hA5C);
        chk("t1_rd",   {20'd0, rd_data}, 32'hA5C);
        cycles(1);
        chk("t1_valid_pulse", {31'd0, sample_valid}, 32'd0);

        // Drop enable about 100 cycles into the following frame.
        cycles(98);
        enable = 1'b0;
        prev = at;
        wait_valid("t4", 700, at);
        chk("t4_spacing", at - prev, 32'd512);
        chk("t4_data", {20'd0, sample_data}, 32'hA5C);
        chk("t4_cs_high", {31'd0, adc_cs_n}, 32'd1);
        chk("t4_sclk_high", {31'd0, adc_sclk}, 32'd1);
        edges = m_edges;
        cycles(200);
        chk("t4_no_sclk", m_edges, edges);
        chk("t4_cs_idle", {31'd0, adc_cs_n}, 32'd1);

        // Three-channel round robin.
        ch_enable = 8'b1000_0101;
        for (int i = 0; i < 8; i++) m_val[i] = 12'(12'h100 * (i + 1));
        q0 = q_addr.size();
        start_run(t_cs);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_valid("t2", 1200, at);
            chk("t2_ch", {29'd0, sample_ch}, {29'd0, exp_ch[i]});
            chk("t2_data", {20'd0, sample_data}, 32'(12'h100 * (exp_ch[i] + 1)));
            if (i > 0) chk("t2_spacing", at - prev, 32'd512);
            prev = at;
        end
        chk("t2_addr_count_ok", {31'd0, q_addr.size() >= q0 + 4}, 32'd1);
        for (int j = 0; j < 4; j++)
            if (q_addr.size() > q0 + j)
                chk("t2_saddr", {29'd0, q_addr[q0 + j]}, {29'd0, exp_addr[j]});
        rd_ch = 3'd7; #1;
        chk("t2_rd7", {20'd0, rd_data}, 32'h800);
        rd_ch = 3'd0;
        enable = 1'b0;
        wait_valid("t2_tail", 700, at);
        cycles(50);

        // Only IN2 enabled: the IN0 frame is discarded.
        ch_enable = 8'h04;
        start_run(t_cs);
        wait_valid("t3", 1300, at);
        chk("t3_latency", at - t_cs, 32'd1040);
        chk("t3_ch", {29'd0, sample_ch}, 32'd2);
        chk("t3_data", {20'd0, sample_data}, 32'h300);
        prev = at;
        wait_valid("t3b", 700, at);
        chk("t3_spacing", at - prev, 32'd512);
        chk("t3b_ch", {29'd0, sample_ch}, 32'd2);
        enable = 1'b0;
        wait_valid("t3_tail", 700, at);
        cycles(50);

        // Obstacle flag on IN1 around the threshold.
        ch_enable = 8'h02;
        m_val[1] = 12'h800;
        start_run(t_cs);
        wait_valid("t6", 1300, at);
        chk("t6_ch", {29'd0, sample_ch}, 32'd1);
        chk("t6_data", {20'd0, sample_data}, 32'h800);
        chk("t6_obst_hi", {24'd0, obstacle}, {24'd0, OBS_HI});
        m_val[1] = 12'h7FF;
        wait_valid("t6b", 700, at);
        chk("t6b_data", {20'd0, sample_data}, 32'h7FF);
        chk("t6_obst_lo", {24'd0, obstacle}, 32'd0);
        enable = 1'b0;
        wait_valid("t6_tail", 700, at);
        cycles(50);

        // Asynchronous reset during SHIFT with SCLK low.
        ch_enable = 8'b1000_0101;
        start_run(t_cs);
        cycles(300);
        for (int i = 0; i < 64; i++) begin
            if (adc_sclk === 1'b0) break;
            @(posedge clk_50); #1;
        end
        chk("t5_sclk_low_pre", {31'd0, adc_sclk}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_cs_n", {31'd0, adc_cs_n}, 32'd1);
        chk("t5_sclk", {31'd0, adc_sclk}, 32'd1);
        chk("t5_obst", {24'd0, obstacle}, 32'd0);
        chk("t5_data", {20'd0, sample_data}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_ch = 3'(r);
            #1;
            chk("t5_rd_clear", {20'd0, rd_data}, 32'd0);
        end
        enable = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
